bcd_serial_add_ctrl: RTL and testbench

Multi-digit BCD adder controller that time-shares one single-digit BCD add stage across DIGITS digit positions, one digit per clock, LSD first.
- Latches operands on a start request, ripples the decimal carry through an internal register, assembles the sum digit by digit, and reports completion with a done pulse.
- Sits between the switch/key input logic and the seven-segment display path. It replaces wide combinational BCD adders when digit count grows.

---
 rtl/bcd_serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared single-digit stage, LSD first.
// Optional BCD_SUBTRACT_EN adds a 'sub' port for ten's-complement A-B.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a_in,
    input  logic [4*DIGITS-1:0] b_in,
`ifdef BCD_SUBTRACT_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_inv;
    logic                r_sub;
    logic                w_sub_in;

    logic [3:0] w_a_d;
    logic [3:0] w_b_d;
    logic [3:0] w_b_eff;
    logic [4:0] w_t;
    logic       w_gt9;
    logic [3:0] w_dig;
    logic       w_bad;
    logic       w_last;

`ifdef BCD_SUBTRACT_EN
    assign w_sub_in = sub;
    // Nines complement in 4-bit arithmetic; raw B is still used for invalid.
    assign w_b_eff  = r_sub ? (4'd9 - w_b_d) : w_b_d;
`else
    assign w_sub_in = 1'b0;
    assign w_b_eff  = w_b_d;
`endif

    assign w_a_d  = r_a[4*r_idx +: 4];
    assign w_b_d  = r_b[4*r_idx +: 4];
    assign w_t    = 5'(w_a_d) + 5'(w_b_eff) + 5'(r_carry);
    assign w_gt9  = (w_t > 5'd9);
    assign w_dig  = w_gt9 ? 4'(w_t - 5'd10) : w_t[3:0];
    assign w_bad  = (w_a_d > 4'd9) | (w_b_d > 4'd9);
    assign w_last = (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_ADD;
            S_ADD:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_inv   <= 1'b0;
            r_sub   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_a     <= a_in;
                r_b     <= b_in;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_inv   <= 1'b0;
                r_idx   <= '0;
                r_carry <= w_sub_in;
                r_sub   <= w_sub_in;
            end
        end else if (r_state == S_ADD) begin
            r_sum[4*r_idx +: 4] <= w_dig;
            r_carry             <= w_gt9;
            r_inv               <= r_inv | w_bad;
            if (w_last) begin
                r_cout <= w_gt9;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy    = (r_state == S_ADD);
    assign done    = (r_state == S_DONE);
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_inv;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=4).
// Subtract scenarios are compiled in when BCD_SUBTRACT_EN is defined.
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         inv;
    } exp_t;

    exp_t exp_q[$];
    int   vectors;
    int   errors;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
`ifdef BCD_SUBTRACT_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic s);
        exp_t e;
        int c;
        int t;
        int ad;
        int bd;
        e   = '0;
        c   = s ? 1 : 0;
        for (int i = 0; i < D; i++) begin
            ad = int'(a[4*i +: 4]);
            bd = int'(b[4*i +: 4]);
            if (ad > 9 || bd > 9) e.inv = 1'b1;
            if (s) bd = (9 - bd) & 15;
            t = ad + bd + c;
            if (t > 9) begin
                e.s[4*i +: 4] = 4'(t - 10);
                c = 1;
            end else begin
                e.s[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        e.c = (c != 0);
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input string tag);
        exp_t e;
        int   k;
        int   nb;
        logic [W-1:0] held;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = 16'($urandom);
        sub   = ~s;
        k  = 1;
        nb = 0;
        while (!done && k < 20) begin
            if (busy) nb++;
            @(negedge clk);
            k++;
        end
        e = exp_q.pop_front();
        vectors++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done never seen, waited %0d cycles",
                     tag, k);
            return;
        end
        if (k !== D + 1) begin
            errors++;
            $display("FAIL %s latency: done in cycle %0d, expected %0d",
                     tag, k, D + 1);
        end
        vectors++;
        if (nb !== D) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", tag, nb, D);
        end
        vectors++;
        if (sum !== e.s) begin
            errors++;
            $display("FAIL %s sum: got %h, expected %h", tag, sum, e.s);
        end
        vectors++;
        if (cout !== e.c) begin
            errors++;
            $display("FAIL %s cout: got %b, expected %b", tag, cout, e.c);
        end
        vectors++;
        if (invalid !== e.inv) begin
            errors++;
            $display("FAIL %s invalid: got %b, expected %b",
                     tag, invalid, e.inv);
        end
        held = sum;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== held) begin
            errors++;
            $display("FAIL %s hold: done=%b busy=%b sum=%h, expected 0 0 %h",
                     tag, done, busy, sum, held);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        sub    = 1'b0;
        #2 resetn = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout, invalid} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b inv=%b, expected all 0",
                     busy, done, sum, cout, invalid);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_plan_vectors();
        exp_t e;
        do_op(16'h1234, 16'h5678, 1'b0, "add_1234_5678");
        e = model(16'h1234, 16'h5678, 1'b0);
        vectors++;
        if (sum !== 16'h6912 || cout !== 1'b0 || e.s !== 16'h6912) begin
            errors++;
            $display("FAIL const_6912: got %h/%b, expected 6912/0", sum, cout);
        end
        do_op(16'h9999, 16'h0001, 1'b0, "ripple_9999_0001");
        vectors++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL const_ripple: got %h/%b, expected 0000/1", sum, cout);
        end
        do_op(16'h00A3, 16'h0001, 1'b0, "invalid_00A3");
        vectors++;
        if (sum !== 16'h0104 || invalid !== 1'b1) begin
            errors++;
            $display("FAIL const_invalid: got %h/%b, expected 0104/1",
                     sum, invalid);
        end
        do_op(16'h0000, 16'h0000, 1'b0, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            do_op(rand_bcd(), rand_bcd(), 1'b0, "random_add");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa[3];
        logic [W-1:0] ob[3];
        exp_t e;
        int   n;
        int   ndone;
        int   gcnt;
        int   last;
        oa[0] = 16'h1234; ob[0] = 16'h5678;
        oa[1] = 16'h9999; ob[1] = 16'h0001;
        oa[2] = 16'h4321; ob[2] = 16'h8765;
        @(negedge clk);
        a_in  = oa[0];
        b_in  = ob[0];
        sub   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(oa[0], ob[0], 1'b0));
        n     = 1;
        ndone = 0;
        gcnt  = 1;
        last  = -1;
        for (int cyc = 1; cyc < 60 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (gcnt > 0) begin
                gcnt--;
                if (gcnt == 0) begin
                    a_in = 16'($urandom);
                    b_in = 16'($urandom);
                end
            end
            if (done) begin
                e = exp_q.pop_front();
                vectors++;
                if (sum !== e.s || cout !== e.c || invalid !== e.inv) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h/%b/%b, expected %h/%b/%b",
                             ndone, sum, cout, invalid, e.s, e.c, e.inv);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== D + 2) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d, expected %0d",
                                 cyc - last, D + 2);
                    end
                end
                last = cyc;
                ndone++;
                if (n < 3) begin
                    a_in = oa[n];
                    b_in = ob[n];
                    exp_q.push_back(model(oa[n], ob[n], 1'b0));
                    n++;
                    gcnt = 2;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d dones, expected 3", ndone);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a_in  = 16'h123A;
        b_in  = 16'h5678;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout, invalid} !== '0) begin
            errors++;
            $display("FAIL midop_reset: busy=%b done=%b sum=%h cout=%b inv=%b, expected all 0",
                     busy, done, sum, cout, invalid);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midop_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
        do_op(16'h2468, 16'h1357, 1'b0, "after_reset");
    endtask

`ifdef BCD_SUBTRACT_EN
    task automatic test_subtract();
        do_op(16'h0042, 16'h0017, 1'b1, "sub_pos");
        vectors++;
        if (sum !== 16'h0025 || cout !== 1'b1) begin
            errors++;
            $display("FAIL const_sub_pos: got %h/%b, expected 0025/1", sum, cout);
        end
        do_op(16'h0017, 16'h0042, 1'b1, "sub_neg");
        vectors++;
        if (sum !== 16'h9975 || cout !== 1'b0) begin
            errors++;
            $display("FAIL const_sub_neg: got %h/%b, expected 9975/0", sum, cout);
        end
        for (int i = 0; i < 4; i++) begin
            do_op(rand_bcd(), rand_bcd(), 1'b1, "random_sub");
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_plan_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
`ifdef BCD_SUBTRACT_EN
        test_subtract();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
